// File: rtl/master_mem_pkg.sv
// Shared definitions for the master memory sequencer.
//   seq_state_e : sequencer FSM states (idle, row issue, skew drain)
//   lane_lsb()  : bit offset of a lane's slice inside a packed per-lane address bus
package master_mem_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } seq_state_e;

    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mem_lane_skew.sv
// Per-lane {en, addr} register chain feeding the systolic array's SRAM read ports.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   hold_i        : stall; chain holds and the registered outputs go to zero
//   bypass_i      : 1 = every stage loads the input (broadcast), 0 = shift (diagonal skew)
//   flush_i       : clears the whole chain and the outputs
//   in_en_i       : lane-0 enable for this step
//   in_addr_i     : lane-0 address for this step
//   mask_i        : per-lane active mask applied to the registered outputs
//   lane_en_o     : registered per-lane read enable
//   lane_addr_o   : registered per-lane address, lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
module mem_lane_skew
    import master_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LANES      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hold_i,
    input  logic                        bypass_i,
    input  logic                        flush_i,
    input  logic                        in_en_i,
    input  logic [ADDR_WIDTH-1:0]       in_addr_i,
    input  logic [LANES-1:0]            mask_i,
    output logic [LANES-1:0]            lane_en_o,
    output logic [ADDR_WIDTH*LANES-1:0] lane_addr_o
);

    logic [LANES-1:0]                 chain_en_q, chain_en_d;
    logic [LANES-1:0][ADDR_WIDTH-1:0] chain_addr_q, chain_addr_d;
    logic [LANES-1:0]                 out_en_q, out_en_d;
    logic [ADDR_WIDTH*LANES-1:0]      out_addr_q, out_addr_d;

    always_comb begin
        chain_en_d   = chain_en_q;
        chain_addr_d = chain_addr_q;
        out_en_d     = '0;
        out_addr_d   = '0;
        if (flush_i) begin
            chain_en_d   = '0;
            chain_addr_d = '0;
        end else if (!hold_i) begin
            chain_en_d[0]   = in_en_i;
            chain_addr_d[0] = in_addr_i;
            for (int unsigned i = 1; i < LANES; i++) begin
                if (bypass_i) begin
                    chain_en_d[i]   = in_en_i;
                    chain_addr_d[i] = in_addr_i;
                end else begin
                    chain_en_d[i]   = chain_en_q[i-1];
                    chain_addr_d[i] = chain_addr_q[i-1];
                end
            end
            // Outputs mirror the new chain contents, masked; inactive lanes read as zero.
            for (int unsigned i = 0; i < LANES; i++) begin
                if (chain_en_d[i] && mask_i[i]) begin
                    out_en_d[i] = 1'b1;
                    out_addr_d[lane_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH] = chain_addr_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_en_q   <= '0;
            chain_addr_q <= '0;
            out_en_q     <= '0;
            out_addr_q   <= '0;
        end else begin
            chain_en_q   <= chain_en_d;
            chain_addr_q <= chain_addr_d;
            out_en_q     <= out_en_d;
            out_addr_q   <= out_addr_d;
        end
    end

    assign lane_en_o   = out_en_q;
    assign lane_addr_o = out_addr_q;

endmodule

// File: rtl/master_mem_sequencer.sv
// Address sequencer for the systolic array's input memories: per-lane addressing with a
// programmable row stride, column masking, optional diagonal skew, stall and a
// start/busy/done handshake.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start_i      : transfer request, sampled only while idle
//   base_addr_i  : first row address (latched on accepted start)
//   stride_i     : address increment per row (latched)
//   num_row_i    : rows per transfer minus one (latched)
//   num_col_i    : index of the highest active lane (latched)
//   skew_en_i    : 1 = diagonal skew, 0 = broadcast (latched)
//   stall_i      : freezes sequencing; outputs of the following cycle are blanked
//   busy_o       : transfer in progress
//   out_addr_o   : per-lane addresses, lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   out_en_o     : per-lane read enables
//   done_o       : one-cycle completion pulse
module master_mem_sequencer
    import master_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LANES      = 16,
    parameter int unsigned CNT_W      = $clog2(LANES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic [ADDR_WIDTH-1:0]       base_addr_i,
    input  logic [ADDR_WIDTH-1:0]       stride_i,
    input  logic [CNT_W-1:0]            num_row_i,
    input  logic [CNT_W-1:0]            num_col_i,
    input  logic                        skew_en_i,
    input  logic                        stall_i,
    output logic                        busy_o,
    output logic [ADDR_WIDTH*LANES-1:0] out_addr_o,
    output logic [LANES-1:0]            out_en_o,
    output logic                        done_o
);

    // Step count reaches (num_row+1)+num_col <= 2*LANES-1, so one extra bit suffices.
    localparam int unsigned TW = CNT_W + 1;

    seq_state_e            state_q;
    logic                  busy_q, done_q;
    logic [TW-1:0]         t_q;        // steps already issued
    logic [TW-1:0]         total_q;    // T for the current transfer
    logic [ADDR_WIDTH-1:0] acc_q;      // address of the next row to issue
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [CNT_W-1:0]      num_row_q, num_col_q;
    logic                  skew_q;

    logic [TW-1:0]         total_in;
    logic [TW-1:0]         t_inc;
    logic                  row_phase;
    logic [CNT_W-1:0]      mask_col;

    logic                  issue_en, flush, bypass;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [LANES-1:0]      lane_mask;

    assign total_in  = TW'(num_row_i) + TW'(1) + (skew_en_i ? TW'(num_col_i) : '0);
    assign t_inc     = t_q + TW'(1);
    assign row_phase = (t_q <= TW'(num_row_q));

    // Chain drive. On the accepting start edge the live inputs are used because the
    // latches only update at that same edge.
    always_comb begin
        issue_en   = 1'b0;
        issue_addr = acc_q;
        flush      = 1'b0;
        bypass     = ~skew_q;
        mask_col   = num_col_q;
        unique case (state_q)
            StIdle: begin
                issue_en   = start_i;
                issue_addr = base_addr_i;
                bypass     = ~skew_en_i;
                mask_col   = num_col_i;
            end
            StRun, StDrain: begin
                if (t_q == total_q) begin
                    flush = ~stall_i;
                end else begin
                    issue_en = row_phase;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_mask[i] = (CNT_W'(i) <= mask_col);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            t_q       <= '0;
            total_q   <= '0;
            acc_q     <= '0;
            stride_q  <= '0;
            num_row_q <= '0;
            num_col_q <= '0;
            skew_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        stride_q  <= stride_i;
                        num_row_q <= num_row_i;
                        num_col_q <= num_col_i;
                        skew_q    <= skew_en_i;
                        total_q   <= total_in;
                        busy_q    <= 1'b1;
                        if (stall_i) begin
                            // Accepted but frozen: step 0 is issued on the next free edge.
                            acc_q   <= base_addr_i;
                            t_q     <= '0;
                            state_q <= StRun;
                        end else begin
                            acc_q   <= base_addr_i + stride_i;
                            t_q     <= TW'(1);
                            state_q <= (num_row_i == '0 && total_in > TW'(1)) ? StDrain : StRun;
                        end
                    end
                end
                StRun, StDrain: begin
                    if (!stall_i) begin
                        if (t_q == total_q) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            t_q     <= '0;
                        end else begin
                            t_q <= t_inc;
                            if (row_phase) begin
                                acc_q <= acc_q + stride_q;
                            end
                            if (t_inc > TW'(num_row_q) && t_inc < total_q) begin
                                state_q <= StDrain;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    mem_lane_skew #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANES      (LANES)
    ) u_lane_skew (
        .clk         (clk),
        .reset       (reset),
        .hold_i      (stall_i),
        .bypass_i    (bypass),
        .flush_i     (flush),
        .in_en_i     (issue_en),
        .in_addr_i   (issue_addr),
        .mask_i      (lane_mask),
        .lane_en_o   (out_en_o),
        .lane_addr_o (out_addr_o)
    );

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_master_mem_sequencer.sv
// Scoreboard bench for master_mem_sequencer with LANES=4, ADDR_WIDTH=8.
// The driver pushes cycle-tagged expected outputs; a negedge monitor pops and compares
// whenever the DUT shows a non-zero out_en or a done pulse.
module tb_master_mem_sequencer;

    localparam int unsigned AW = 8;
    localparam int unsigned LN = 4;
    localparam int unsigned CW = 2;

    logic          clk;
    logic          reset;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [AW-1:0] stride_i;
    logic [CW-1:0] num_row_i;
    logic [CW-1:0] num_col_i;
    logic          skew_en_i;
    logic          stall_i;
    logic          busy_o;
    logic [AW*LN-1:0] out_addr_o;
    logic [LN-1:0] out_en_o;
    logic          done_o;

    typedef struct {
        int          cyc;
        bit          is_done;
        logic [3:0]  en;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc;
    int   checks;
    int   failures;

    master_mem_sequencer #(
        .ADDR_WIDTH (AW),
        .LANES      (LN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .num_row_i   (num_row_i),
        .num_col_i   (num_col_i),
        .skew_en_i   (skew_en_i),
        .stall_i     (stall_i),
        .busy_o      (busy_o),
        .out_addr_o  (out_addr_o),
        .out_en_o    (out_en_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    // Monitor: one pop per presented output event.
    always @(negedge clk) begin
        if (|out_en_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_step cyc=%0d got en=%b addr=%h want nothing",
                         cyc, out_en_o, out_addr_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_done || mon_e.cyc != cyc || mon_e.en !== out_en_o ||
                    mon_e.addr !== out_addr_o) begin
                    failures++;
                    $display("FAIL step got cyc=%0d en=%b addr=%h want cyc=%0d done=%0d en=%b addr=%h",
                             cyc, out_en_o, out_addr_o, mon_e.cyc, mon_e.is_done, mon_e.en,
                             mon_e.addr);
                end
            end
        end
        if (done_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done cyc=%0d got done=1 want nothing", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (!mon_e.is_done || mon_e.cyc != cyc || busy_o !== 1'b0) begin
                    failures++;
                    $display("FAIL done got cyc=%0d busy=%b want cyc=%0d done_event=%0d busy=0",
                             cyc, busy_o, mon_e.cyc, mon_e.is_done);
                end
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    task automatic push_step(input int c, input logic [3:0] en, input logic [7:0] a0,
                             input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
        exp_t e;
        e.cyc     = c;
        e.is_done = 1'b0;
        e.en      = en;
        e.addr    = {a3, a2, a1, a0};
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int c);
        exp_t e;
        e.cyc     = c;
        e.is_done = 1'b1;
        e.en      = 4'b0000;
        e.addr    = 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input logic [7:0] b, input logic [7:0] s, input logic [1:0] nr,
                           input logic [1:0] nc, input logic sk);
        base_addr_i = b;
        stride_i    = s;
        num_row_i   = nr;
        num_col_i   = nc;
        skew_en_i   = sk;
        start_i     = 1'b1;
    endtask

    int n, m, p, r, q;

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        start_i = 1'b0;
        base_addr_i = '0;
        stride_i = '0;
        num_row_i = '0;
        num_col_i = '0;
        skew_en_i = 1'b0;
        stall_i = 1'b0;

        goto(3);
        reset = 1'b0;
        goto(4);
        chk("reset_busy", 32'(busy_o), 32'h0);
        chk("reset_done", 32'(done_o), 32'h0);
        chk("reset_en", 32'(out_en_o), 32'h0);
        chk("reset_addr", out_addr_o, 32'h0);

        // Broadcast, with an ignored start mid-transfer and a back-to-back start on done.
        n = 5;
        goto(n);
        set_req(8'h10, 8'h01, 2'd3, 2'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            push_step(n + 1 + k, 4'b1111, 8'(8'h10 + k), 8'(8'h10 + k), 8'(8'h10 + k),
                      8'(8'h10 + k));
        end
        push_done(n + 5);
        goto(n + 1);
        start_i = 1'b0;
        chk("bcast_busy", 32'(busy_o), 32'h1);
        goto(n + 2);
        set_req(8'h77, 8'h09, 2'd0, 2'd0, 1'b1);
        goto(n + 3);
        start_i = 1'b0;
        goto(n + 5);
        chk("bcast_done_busy", 32'(busy_o), 32'h0);
        // Wrap: 0xFE + 3 = 0x01 mod 256; only lanes 0..1 active.
        set_req(8'hFE, 8'h03, 2'd2, 2'd1, 1'b0);
        push_step(n + 6, 4'b0011, 8'hFE, 8'hFE, 8'h00, 8'h00);
        push_step(n + 7, 4'b0011, 8'h01, 8'h01, 8'h00, 8'h00);
        push_step(n + 8, 4'b0011, 8'h04, 8'h04, 8'h00, 8'h00);
        push_done(n + 9);
        goto(n + 6);
        start_i = 1'b0;
        chk("b2b_busy", 32'(busy_o), 32'h1);
        goto(n + 10);
        chk("wrap_idle_busy", 32'(busy_o), 32'h0);

        // Skew: T = 2 + 2 = 4.
        m = n + 12;
        goto(m);
        set_req(8'h20, 8'h04, 2'd1, 2'd2, 1'b1);
        push_step(m + 1, 4'b0001, 8'h20, 8'h00, 8'h00, 8'h00);
        push_step(m + 2, 4'b0011, 8'h24, 8'h20, 8'h00, 8'h00);
        push_step(m + 3, 4'b0110, 8'h00, 8'h24, 8'h20, 8'h00);
        push_step(m + 4, 4'b0100, 8'h00, 8'h00, 8'h24, 8'h00);
        push_done(m + 5);
        goto(m + 1);
        start_i = 1'b0;
        goto(m + 4);
        chk("skew_drain_busy", 32'(busy_o), 32'h1);
        goto(m + 6);
        chk("skew_idle_busy", 32'(busy_o), 32'h0);

        // Stall sampled on the edges into cycles p+2 and p+3.
        p = m + 8;
        goto(p);
        set_req(8'h10, 8'h01, 2'd3, 2'd3, 1'b0);
        push_step(p + 1, 4'b1111, 8'h10, 8'h10, 8'h10, 8'h10);
        push_step(p + 4, 4'b1111, 8'h11, 8'h11, 8'h11, 8'h11);
        push_step(p + 5, 4'b1111, 8'h12, 8'h12, 8'h12, 8'h12);
        push_step(p + 6, 4'b1111, 8'h13, 8'h13, 8'h13, 8'h13);
        push_done(p + 7);
        goto(p + 1);
        start_i = 1'b0;
        stall_i = 1'b1;
        goto(p + 2);
        chk("stall_en", 32'(out_en_o), 32'h0);
        chk("stall_addr", out_addr_o, 32'h0);
        chk("stall_busy", 32'(busy_o), 32'h1);
        goto(p + 3);
        stall_i = 1'b0;
        goto(p + 8);
        chk("stall_idle_busy", 32'(busy_o), 32'h0);

        // Reset mid-skew-transfer: no done, then a T=1 transfer is accepted.
        r = p + 10;
        goto(r);
        set_req(8'h20, 8'h04, 2'd1, 2'd2, 1'b1);
        push_step(r + 1, 4'b0001, 8'h20, 8'h00, 8'h00, 8'h00);
        push_step(r + 2, 4'b0011, 8'h24, 8'h20, 8'h00, 8'h00);
        goto(r + 1);
        start_i = 1'b0;
        goto(r + 2);
        reset = 1'b1;
        goto(r + 3);
        reset = 1'b0;
        chk("abort_en", 32'(out_en_o), 32'h0);
        chk("abort_addr", out_addr_o, 32'h0);
        chk("abort_busy", 32'(busy_o), 32'h0);
        chk("abort_done", 32'(done_o), 32'h0);

        q = r + 8;
        goto(q);
        set_req(8'h40, 8'h10, 2'd0, 2'd0, 1'b0);
        push_step(q + 1, 4'b0001, 8'h40, 8'h00, 8'h00, 8'h00);
        push_done(q + 2);
        goto(q + 1);
        start_i = 1'b0;
        chk("restart_busy", 32'(busy_o), 32'h1);
        goto(q + 5);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/master_mem_sequencer.md
# master_mem_sequencer

Parametrised address sequencer that feeds the systolic array's input memories. It replaces the single broadcast-address master control with several features: per-lane addressing, programmable row stride, column masking, an optional diagonal skew (lane i lags lane i-1 by one cycle), a stall input, and a start/busy/done handshake. It sits between the top-level controller and the per-lane SRAM read ports.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of one lane address.
- LANES, 16, number of array lanes (power of two, ≥2).
- CNT_W, $clog2(LANES), width of the num_row and num_col fields.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first row address; latched on accepted start.
- stride  in  ADDR_WIDTH  address increment per row; latched.
- num_row  in  CNT_W  rows per transfer minus 1; latched.
- num_col  in  CNT_W  index of the highest active lane; latched.
- skew_en  in  1  1 = diagonal skew, 0 = broadcast; latched.
- stall  in  1  freezes sequencing for the current cycle.
- busy  out  1  transfer in progress.
- out_addr  out  ADDR_WIDTH*LANES  lane i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- out_en  out  LANES  per-lane read enable.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: waits for start.
  - RUN: step counter t runs from 0 to num_row; lane 0 is active.
  - DRAIN: only when skew_en=1; runs num_col further steps while the delay chain empties.
  - Transitions: IDLE→RUN on start. RUN→DRAIN on the last step if skew_en && num_col≠0. RUN or DRAIN→IDLE after the last step.
- Step count: T = (num_row+1) + (skew_en ? num_col : 0).
- Lane-0 address: a row accumulator. It is loaded with base_addr and adds stride on each non-stalled RUN step. All arithmetic is modulo 2^ADDR_WIDTH (wraps, no saturation).
- Broadcast mode: every lane i ≤ num_col gets lane 0's address and enable.
- Skew mode: lane i's address/enable equal lane i-1's from the previous non-stalled step, masked by i ≤ num_col.
- Lanes with i > num_col have out_en=0.
- When a lane's out_en=0, its out_addr is driven to 0.
- Stall:
  - During a stall the counter, accumulator and delay chain all hold.
  - out_en is forced to all-zero and out_addr drives 0.
  - Completion is delayed by one cycle per stalled cycle.
- start while busy is ignored. Inputs other than stall are don't-care after latching.
- done pulses in the first IDLE cycle after the transfer. A start in that same cycle is accepted, giving back-to-back transfers.
- Reset, including mid-transfer:
  - FSM goes to IDLE; counter, accumulator and delay chain clear.
  - busy=0, done=0, out_en=0, out_addr=0 from the cycle after reset is sampled.
  - No done pulse is issued for an aborted transfer.

## Timing
- All outputs are registered.
- start sampled high in cycle N → busy=1 and the first step is visible in cycle N+1.
- Step k (0-based, no stalls) is visible in cycle N+1+k.
- The last step is in cycle N+T. done=1 and busy=0 in cycle N+T+1, with S added for S stalled cycles.
- Skew mode: lane i's address for row r appears in cycle N+1+r+i.
- stall affects the same cycle's outputs, i.e. the cycle after stall is sampled.

## Structure
- Shared package master_mem_pkg holds the FSM state enum (IDLE, RUN, DRAIN) and a lane-slice helper function for out_addr packing.
- Sub-module mem_lane_skew: a LANES-deep register chain of {en, addr} with a hold (stall) input and a bypass (broadcast) select. It is instantiated once.
- The top level holds the FSM, step counter, row accumulator, parameter latches and num_col masking.

## Test plan
The bench uses LANES=4 and ADDR_WIDTH=8; start is high in cycle 0.
1. Broadcast: base=0x10, stride=1, num_row=3, num_col=3, skew_en=0 → in cycles 1–4 every lane reads 0x10, 0x11, 0x12, 0x13 with out_en=4'b1111; done in cycle 5.
2. Skew: base=0x20, stride=4, num_row=1, num_col=2, skew_en=1 → T=4.
   - Cycle 1: lane0=0x20.
   - Cycle 2: lane0=0x24, lane1=0x20.
   - Cycle 3: lane1=0x24, lane2=0x20.
   - Cycle 4: lane2=0x24.
   - Lane 3 en=0 throughout; done in cycle 5.
3. Wrap: base=0xFE, stride=3, num_row=2, broadcast → addresses 0xFE, 0x01, 0x04.
4. Stall: scenario 1 with stall high in cycles 2–3 → out_en=0 in those cycles; 0x11–0x13 appear in cycles 4–6; done in cycle 7.
5. Handshake:
   - start pulsed in cycle 2 of scenario 1 → ignored.
   - start held in the done cycle (cycle 5) → the second transfer's first step appears in cycle 6.
6. Reset: reset high in cycle 2 of scenario 2 → from cycle 3 all outputs are 0 and busy=0; no done pulse; a new start is accepted afterwards.
